// File: rtl/vram_ctrl.sv
// vram_ctrl -- sequencer and arbiter for the 80x60 text VRAM (dual-port BRAM).
//
// Port A (write-only) is shared between CPU bus writes and a fill/scroll
// engine; the CPU always wins and the engine simply retries its write slot.
// Port B is the VGA character-fetch port; the scroll engine borrows it only
// while the VGA controller is blanking (vga_rdn = 1).
//
// Optional feature: define VRAM_CTRL_SCROLL_EN to build the SCROLL_UP engine
// and port B stealing. Without it, op 10 completes immediately with no
// writes and port B is permanently the VGA fetch address.
//
// Ports:
//   clk, RSTN                       clock, asynchronous active-low reset
//   cpu_we/cpu_addr/cpu_din         CPU write channel (never stalled)
//   cmd_valid/cmd_op/cmd_row/       engine command (00 CLEAR_ALL, 01 CLEAR_LINE,
//   cmd_char/cmd_ready              10 SCROLL_UP, 11 reserved)
//   busy, done                      engine executing / one-cycle completion pulse
//   vga_rdn, vga_addr               VGA read enable (active low) and address
//   vram_we/vram_addra/vram_dina    VRAM port A
//   vram_addrb/vram_doutb           VRAM port B (one-cycle read latency)
module vram_ctrl #(
   parameter int COLS = 80,
   parameter int ROWS = 60,
   parameter int AW   = 13,
   parameter int DW   = 7
) (
   input  logic          clk,
   input  logic          RSTN,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   input  logic          cmd_valid,
   input  logic [1:0]    cmd_op,
   input  logic [5:0]    cmd_row,
   input  logic [DW-1:0] cmd_char,
   output logic          cmd_ready,
   output logic          busy,
   output logic          done,
   input  logic          vga_rdn,
   input  logic [AW-1:0] vga_addr,
   output logic          vram_we,
   output logic [AW-1:0] vram_addra,
   output logic [DW-1:0] vram_dina,
   output logic [AW-1:0] vram_addrb,
   input  logic [DW-1:0] vram_doutb
);

   localparam logic [AW-1:0] ONE       = AW'(1);
   localparam logic [AW-1:0] COLS_A    = AW'(COLS);
   localparam logic [AW-1:0] LAST_CELL = AW'(COLS*ROWS-1);
`ifdef VRAM_CTRL_SCROLL_EN
   localparam logic [AW-1:0] LAST_ROW_BASE = AW'(COLS*(ROWS-1));
   localparam logic [AW-1:0] COPY_LAST     = AW'(COLS*(ROWS-1)-1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      DONE
`ifdef VRAM_CTRL_SCROLL_EN
      ,
      COPY_RD,
      COPY_WAIT,
      COPY_WR
`endif
   } state_t;

   state_t        state;
   logic [AW-1:0] ptr;
   logic [AW-1:0] last;
   logic [DW-1:0] fill_char;
   logic          row_ok;
   logic [AW-1:0] row_base;
   logic          eng_we;
   logic [AW-1:0] eng_addr;
   logic [DW-1:0] eng_data;
`ifdef VRAM_CTRL_SCROLL_EN
   logic [AW-1:0] dst;
   logic [DW-1:0] cap_data;
`endif

   assign row_ok   = (AW'(cmd_row) < AW'(ROWS));
   assign row_base = AW'(cmd_row) * COLS_A;

   // Control FSM; outputs are registered alongside the state.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         ptr       <= '0;
         last      <= '0;
`ifdef VRAM_CTRL_SCROLL_EN
         dst       <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  case (cmd_op)
                     2'b00: begin
                        state <= FILL;
                        ptr   <= '0;
                        last  <= LAST_CELL;
                     end
                     2'b01: begin
                        if (row_ok) begin
                           state <= FILL;
                           ptr   <= row_base;
                           last  <= row_base + COLS_A - ONE;
                        end else begin
                           state <= DONE;
                           done  <= 1'b1;
                        end
                     end
`ifdef VRAM_CTRL_SCROLL_EN
                     2'b10: begin
                        state <= COPY_RD;
                        dst   <= '0;
                     end
`endif
                     default: begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  endcase
               end
            end
            FILL: begin
               // A CPU write owns port A this cycle; retry the same cell.
               if (!cpu_we) begin
                  if (ptr == last) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     ptr <= ptr + ONE;
                  end
               end
            end
`ifdef VRAM_CTRL_SCROLL_EN
            COPY_RD: begin
               if (vga_rdn) state <= COPY_WAIT;
            end
            COPY_WAIT: begin
               state <= COPY_WR;
            end
            COPY_WR: begin
               if (!cpu_we) begin
                  if (dst == COPY_LAST) begin
                     // Copy finished; blank the bottom row with the fill char.
                     state <= FILL;
                     ptr   <= LAST_ROW_BASE;
                     last  <= LAST_CELL;
                  end else begin
                     dst   <= dst + ONE;
                     state <= COPY_RD;
                  end
               end
            end
`endif
            DONE: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Data registers carry no reset; they are only read after being loaded.
   always_ff @(posedge clk) begin
      if (state == IDLE && cmd_valid) fill_char <= cmd_char;
`ifdef VRAM_CTRL_SCROLL_EN
      // Read issued in COPY_RD returns here regardless of vga_rdn now.
      if (state == COPY_WAIT) cap_data <= vram_doutb;
`endif
   end

   always_comb begin
      eng_we   = 1'b0;
      eng_addr = ptr;
      eng_data = fill_char;
      if (state == FILL) eng_we = 1'b1;
`ifdef VRAM_CTRL_SCROLL_EN
      if (state == COPY_WR) begin
         eng_we   = 1'b1;
         eng_addr = dst;
         eng_data = cap_data;
      end
`endif
   end

   // CPU has unconditional priority on port A.
   assign vram_we    = cpu_we | eng_we;
   assign vram_addra = cpu_we ? cpu_addr : eng_addr;
   assign vram_dina  = cpu_we ? cpu_din  : eng_data;

`ifdef VRAM_CTRL_SCROLL_EN
   assign vram_addrb = (state == COPY_RD && vga_rdn) ? dst + COLS_A : vga_addr;
`else
   logic unused_inputs;
   assign unused_inputs = ^{vga_rdn, vram_doutb};
   assign vram_addrb    = vga_addr;
`endif

endmodule

// File: tb/tb_vram_ctrl.sv
// Directed testbench for vram_ctrl with a behavioural dual-port VRAM model.
module tb_vram_ctrl;

   localparam int AW = 13;
   localparam int DW = 7;

   logic          clk = 1'b0;
   logic          RSTN = 1'b1;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_din = '0;
   logic          cmd_valid = 1'b0;
   logic [1:0]    cmd_op = '0;
   logic [5:0]    cmd_row = '0;
   logic [DW-1:0] cmd_char = '0;
   logic          cmd_ready, busy, done;
   logic          vga_rdn = 1'b1;
   logic [AW-1:0] vga_addr = '0;
   logic          vram_we;
   logic [AW-1:0] vram_addra, vram_addrb;
   logic [DW-1:0] vram_dina;
   logic [DW-1:0] doutb_q;

   logic [DW-1:0] mem [0:8191];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vram_ctrl dut (
      .clk(clk), .RSTN(RSTN),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_char(cmd_char),
      .cmd_ready(cmd_ready), .busy(busy), .done(done),
      .vga_rdn(vga_rdn), .vga_addr(vga_addr),
      .vram_we(vram_we), .vram_addra(vram_addra), .vram_dina(vram_dina),
      .vram_addrb(vram_addrb), .vram_doutb(doutb_q)
   );

   always @(posedge clk) begin
      if (vram_we) mem[vram_addra] <= vram_dina;
      doutb_q <= mem[vram_addrb];
   end

   // Stimulus: CPU writes through port A while the engine is idle.
   task automatic cpu_fill(input int lo, input int hi, input bit modv, input logic [DW-1:0] v);
      for (int a = lo; a <= hi; a++) begin
         cpu_we   = 1'b1;
         cpu_addr = AW'(a);
         cpu_din  = modv ? DW'(a % 128) : v;
         @(posedge clk); #1;
      end
      cpu_we = 1'b0;
      @(negedge clk);
   endtask

   // Stimulus plus measurement for one command; callers judge the results.
   task automatic run_cmd(input logic [1:0] op, input logic [5:0] row, input logic [DW-1:0] ch,
                          input int stall_at, input bit toggle, input bit hold,
                          input logic [AW-1:0] seq_lo, input int budget,
                          output int done_cyc, output int n_done, output int n_wr,
                          output int seq_err, output int cpu_err, output int pb_err,
                          output logic rdy_after);
      logic [AW-1:0] exp_a;
      done_cyc = -1; n_done = 0; n_wr = 0; seq_err = 0; cpu_err = 0; pb_err = 0;
      rdy_after = 1'bx;
      exp_a = seq_lo;
      cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_char = ch;
      @(posedge clk); #1;
      for (int k = 1; k <= budget; k++) begin
         cmd_valid = hold && (n_done == 0);
         cmd_op = 2'b01; cmd_row = 6'd0; cmd_char = 7'h11;
         cpu_we   = (k == stall_at);
         cpu_addr = 13'h100;
         cpu_din  = 7'h7F;
         vga_rdn  = toggle ? ((k / 8) % 2 == 0) : 1'b1;
         vga_addr = AW'((k * 37) % 4800);
         @(negedge clk);
         if (done === 1'b1) begin
            n_done++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (done_cyc > 0 && k == done_cyc + 1) rdy_after = cmd_ready;
         if (cpu_we && (vram_we !== 1'b1 || vram_addra !== cpu_addr || vram_dina !== cpu_din))
            cpu_err++;
         if (vram_we === 1'b1 && !cpu_we) begin
            n_wr++;
            if (vram_addra !== exp_a || vram_dina !== ch) seq_err++;
            exp_a = exp_a + 13'd1;
         end
         if (!vga_rdn && vram_addrb !== vga_addr) pb_err++;
         if (done_cyc > 0 && k >= done_cyc + 3) break;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      cpu_we    = 1'b0;
      vga_rdn   = 1'b1;
   endtask

   task automatic test_reset;
      cpu_we = 1'b1; cpu_addr = 13'h123; cpu_din = 7'h5A;
      vga_rdn = 1'b0; vga_addr = 13'h0AB;
      #3 RSTN = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (vram_we !== 1'b1 || vram_addra !== 13'h123 || vram_dina !== 7'h5A) begin
         errors++; $display("FAIL reset_porta_cpu: got we=%b addr=%h din=%h expected 1 123 5a", vram_we, vram_addra, vram_dina); end
      checks++; if (vram_addrb !== 13'h0AB) begin errors++; $display("FAIL reset_portb: got %h expected 0ab", vram_addrb); end
      cpu_we = 1'b0;
      #1;
      checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL reset_we_follows_cpu: got %b expected 0", vram_we); end
      @(negedge clk);
      RSTN = 1'b1;
      vga_rdn = 1'b1;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b expected 1 0", cmd_ready, busy); end
   endtask

   task automatic test_clear_all;
      int dc, nd, nw, se, ce, pe, bad;
      logic ra;
      cpu_fill(4800, 4800, 1'b0, 7'h55);
      run_cmd(2'b00, 6'd0, 7'h20, 0, 1'b0, 1'b0, 13'd0, 6000, dc, nd, nw, se, ce, pe, ra);
      checks++; if (dc != 4801) begin errors++; $display("FAIL clear_all_done_cycle: got %0d expected 4801", dc); end
      checks++; if (nd != 1) begin errors++; $display("FAIL clear_all_done_count: got %0d expected 1", nd); end
      checks++; if (nw != 4800) begin errors++; $display("FAIL clear_all_writes: got %0d expected 4800", nw); end
      checks++; if (se != 0) begin errors++; $display("FAIL clear_all_sequence: got %0d bad writes expected 0", se); end
      checks++; if (ra !== 1'b1) begin errors++; $display("FAIL clear_all_ready_after: got %b expected 1", ra); end
      bad = 0;
      for (int i = 0; i < 4800; i++) if (mem[i] !== 7'h20) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL clear_all_cells: got %0d wrong cells expected 0", bad); end
      checks++; if (mem[4800] !== 7'h55) begin errors++; $display("FAIL clear_all_beyond: got %h expected 55", mem[4800]); end
   endtask

   task automatic test_clear_line;
      int dc, nd, nw, se, ce, pe, bad;
      logic ra;
      cpu_fill(399, 399, 1'b0, 7'h55);
      cpu_fill(480, 480, 1'b0, 7'h55);
      run_cmd(2'b01, 6'd5, 7'h41, 10, 1'b0, 1'b0, 13'd400, 200, dc, nd, nw, se, ce, pe, ra);
      checks++; if (dc != 82) begin errors++; $display("FAIL clear_line_done_cycle: got %0d expected 82", dc); end
      checks++; if (nw != 80) begin errors++; $display("FAIL clear_line_writes: got %0d expected 80", nw); end
      checks++; if (se != 0) begin errors++; $display("FAIL clear_line_sequence: got %0d bad writes expected 0", se); end
      checks++; if (ce != 0) begin errors++; $display("FAIL clear_line_cpu_priority: got %0d bad cycles expected 0", ce); end
      bad = 0;
      for (int i = 400; i < 480; i++) if (mem[i] !== 7'h41) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL clear_line_cells: got %0d wrong cells expected 0", bad); end
      checks++; if (mem[399] !== 7'h55 || mem[480] !== 7'h55) begin
         errors++; $display("FAIL clear_line_neighbours: got %h %h expected 55 55", mem[399], mem[480]); end
      checks++; if (mem[256] !== 7'h7F) begin errors++; $display("FAIL clear_line_cpu_cell: got %h expected 7f", mem[256]); end
   endtask

   task automatic test_invalid;
      int dc, nd, nw, se, ce, pe;
      logic ra;
      run_cmd(2'b01, 6'd60, 7'h11, 0, 1'b0, 1'b0, 13'd0, 50, dc, nd, nw, se, ce, pe, ra);
      checks++; if (dc != 1 || nw != 0) begin
         errors++; $display("FAIL bad_row: got done_cycle=%0d writes=%0d expected 1 0", dc, nw); end
      checks++; if (ra !== 1'b1) begin errors++; $display("FAIL bad_row_ready: got %b expected 1", ra); end
      run_cmd(2'b11, 6'd0, 7'h11, 0, 1'b0, 1'b0, 13'd0, 50, dc, nd, nw, se, ce, pe, ra);
      checks++; if (dc != 1 || nw != 0 || nd != 1) begin
         errors++; $display("FAIL op11: got done_cycle=%0d writes=%0d dones=%0d expected 1 0 1", dc, nw, nd); end
   endtask

   task automatic test_scroll;
      int dc, nd, nw, se, ce, pe, bad;
      logic ra;
`ifdef VRAM_CTRL_SCROLL_EN
      cpu_fill(0, 4799, 1'b1, 7'h00);
      run_cmd(2'b10, 6'd0, 7'h00, 0, 1'b1, 1'b0, 13'd0, 40000, dc, nd, nw, se, ce, pe, ra);
      checks++; if (dc < 0 || nd != 1) begin
         errors++; $display("FAIL scroll_toggle_done: got cycle=%0d dones=%0d expected one done", dc, nd); end
      checks++; if (nw != 4800) begin errors++; $display("FAIL scroll_writes: got %0d expected 4800", nw); end
      checks++; if (pe != 0) begin errors++; $display("FAIL scroll_portb_vga: got %0d bad cycles expected 0", pe); end
      bad = 0;
      for (int i = 0; i < 4720; i++) if (mem[i] !== DW'((i + 80) % 128)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL scroll_cells: got %0d wrong cells expected 0", bad); end
      bad = 0;
      for (int i = 4720; i < 4800; i++) if (mem[i] !== 7'h00) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL scroll_last_row: got %0d wrong cells expected 0", bad); end
      run_cmd(2'b10, 6'd0, 7'h00, 0, 1'b0, 1'b0, 13'd0, 16000, dc, nd, nw, se, ce, pe, ra);
      checks++; if (dc != 14241) begin errors++; $display("FAIL scroll_done_cycle: got %0d expected 14241", dc); end
`else
      cpu_fill(0, 0, 1'b0, 7'h3C);
      run_cmd(2'b10, 6'd0, 7'h00, 0, 1'b0, 1'b0, 13'd0, 50, dc, nd, nw, se, ce, pe, ra);
      checks++; if (dc != 1 || nw != 0 || nd != 1) begin
         errors++; $display("FAIL scroll_disabled: got done_cycle=%0d writes=%0d dones=%0d expected 1 0 1", dc, nw, nd); end
      checks++; if (mem[0] !== 7'h3C) begin errors++; $display("FAIL scroll_disabled_cell: got %h expected 3c", mem[0]); end
`endif
   endtask

   task automatic test_busy_ignore;
      int dc, nd, nw, se, ce, pe, bad;
      logic ra;
      run_cmd(2'b00, 6'd0, 7'h33, 0, 1'b0, 1'b1, 13'd0, 6000, dc, nd, nw, se, ce, pe, ra);
      checks++; if (dc != 4801 || nd != 1) begin
         errors++; $display("FAIL busy_ignore_done: got cycle=%0d dones=%0d expected 4801 1", dc, nd); end
      checks++; if (nw != 4800 || se != 0) begin
         errors++; $display("FAIL busy_ignore_writes: got %0d writes %0d bad expected 4800 0", nw, se); end
      bad = 0;
      for (int i = 0; i < 80; i++) if (mem[i] !== 7'h33) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL busy_ignore_row0: got %0d wrong cells expected 0", bad); end
   endtask

   task automatic test_reset_mid;
      int dc, nd, nw, se, ce, pe, bad;
      logic ra;
`ifdef VRAM_CTRL_SCROLL_EN
      cmd_op = 2'b10;
`else
      cmd_op = 2'b00;
`endif
      cmd_valid = 1'b1; cmd_row = 6'd0; cmd_char = 7'h00;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
      RSTN = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mid_reset_outputs: got ready=%b busy=%b done=%b expected 1 0 0", cmd_ready, busy, done); end
      checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL mid_reset_we: got %b expected 0", vram_we); end
      @(negedge clk);
      RSTN = 1'b1;
      @(negedge clk);
      run_cmd(2'b00, 6'd0, 7'h0A, 0, 1'b0, 1'b0, 13'd0, 6000, dc, nd, nw, se, ce, pe, ra);
      checks++; if (dc != 4801 || nw != 4800 || se != 0) begin
         errors++; $display("FAIL after_reset_clear: got cycle=%0d writes=%0d bad=%0d expected 4801 4800 0", dc, nw, se); end
      bad = 0;
      for (int i = 0; i < 4800; i++) if (mem[i] !== 7'h0A) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL after_reset_cells: got %0d wrong cells expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_clear_all();
      test_clear_line();
      test_invalid();
      test_scroll();
      test_busy_ignore();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_ctrl.md
Name: vram_ctrl

Overview:
- Sequencer and arbiter for the 80x60 text VRAM, a dual-port block RAM with 7-bit cells.
  - Port A is write-only; this block shares it between CPU writes from the bus and a hardware fill/scroll engine.
  - Port B is the VGA character-fetch read port; the engine borrows it only while VGA is not reading.
- Sits between the bus, the VGA controller and the vram instance.
- Offloads clear-screen, clear-line and scroll-up from software.

Parameters:
- COLS, 80, characters per row.
- ROWS, 60, rows per screen.
- AW, 13, VRAM address width; must satisfy COLS*ROWS <= 2^AW.
- DW, 7, VRAM cell width (character code).

Ports:
- clk  in  1  system clock; same clock as both VRAM ports.
- RSTN  in  1  asynchronous active-low reset.
- cpu_we  in  1  CPU VRAM write strobe, one cell per cycle.
- cpu_addr  in  AW  CPU write address.
- cpu_din  in  DW  CPU write data.
- cmd_valid  in  1  engine command request.
- cmd_op  in  2  opcodes: 00 CLEAR_ALL, 01 CLEAR_LINE, 10 SCROLL_UP, 11 reserved.
- cmd_row  in  6  target row for CLEAR_LINE.
- cmd_char  in  DW  fill character for all ops.
- cmd_ready  out  1  engine idle; a command is accepted when cmd_valid && cmd_ready.
- busy  out  1  engine executing.
- done  out  1  one-cycle completion pulse.
- vga_rdn  in  1  VGA read enable, active low; 1 = blanking, port B free.
- vga_addr  in  AW  VGA fetch address.
- vram_we  out  1  port A write enable.
- vram_addra  out  AW  port A address.
- vram_dina  out  DW  port A data.
- vram_addrb  out  AW  port B address.
- vram_doutb  in  DW  port B data; one-cycle synchronous read latency.

Behaviour:
- Reset (RSTN=0, asynchronous): state IDLE, cmd_ready=1, busy=0, done=0, internal pointers=0.
  - Port A mux selects the CPU path, so vram_we=cpu_we.
  - Reset mid-command aborts immediately; cells already written stay written.
- Port A arbitration, combinational:
  - cpu_we=1: port A carries the CPU access unconditionally and the engine write slot stalls that cycle (the CPU is never stalled).
  - cpu_we=0: the engine drives port A when it has a pending write.
  - A CPU write to the same address as a stalled engine write is not merged; the engine writes afterwards and its data is final.
- Port B mux: vram_addrb=vga_addr, except in COPY_RD with vga_rdn=1, where it equals the engine source address.
- States and transitions:
  - IDLE: cmd_ready=1. On accept, latch op/row/char; cmd_ready=0 and busy=1 from the next cycle.
    - CLEAR_ALL -> FILL with ptr=0, end=COLS*ROWS-1.
    - CLEAR_LINE with cmd_row<ROWS -> FILL with ptr=row*COLS, end=ptr+COLS-1.
    - CLEAR_LINE with cmd_row>=ROWS, or op 11 -> DONE; no writes.
    - SCROLL_UP -> COPY_RD with dst=0.
  - FILL: each cycle without cpu_we, write char to ptr.
    - ptr==end at the write -> DONE; otherwise ptr+1.
  - COPY_RD: wait until vga_rdn=1, then present src=dst+COLS on port B -> COPY_WAIT.
  - COPY_WAIT: capture vram_doutb at the end of this cycle -> COPY_WR. The data is valid even if vga_rdn falls in this cycle.
  - COPY_WR: on a cycle without cpu_we, write the captured data to dst.
    - dst==COLS*(ROWS-1)-1 -> FILL of the last row.
    - Otherwise dst+1 -> COPY_RD.
  - DONE: done=1 and busy=1 for exactly one cycle, cmd_ready=0 -> IDLE.
- cmd_valid while busy is ignored; nothing is queued.
- Uncontended timing:
  - CLEAR_ALL: done asserts 4801 cycles after the accept edge.
  - CLEAR_LINE: done asserts 81 cycles after the accept edge.
  - SCROLL_UP with vga_rdn=1 held: 3*4720 + 80 + 1 = 14241 cycles.
- Address arithmetic is unsigned AW-bit. Pointers never exceed COLS*ROWS-1.

Optional Feature:
- Macro VRAM_CTRL_SCROLL_EN.
- Defined: SCROLL_UP is implemented as above, and port B stealing is present.
- Undefined:
  - Op 10 behaves as reserved: immediate DONE, no writes.
  - COPY_* states and the capture register are absent.
  - vram_addrb=vga_addr permanently.

Test Plan:
- Reset, then CLEAR_ALL char 0x20 with cpu_we=0 -> 4800 writes to addresses 0..4799 of 0x20; done pulse 4801 cycles after accept; cmd_ready=1 next cycle.
- CLEAR_LINE row 5 char 0x41, with cpu_we pulsed at the 10th engine cycle (addr 0x100, data 0x7F) -> CPU write appears on port A that cycle; engine resumes with no skipped cell; cells 400..479=0x41; done at cycle 82.
- CLEAR_LINE row 60 and op 11 -> zero engine writes; done one cycle after accept.
- Preload cell k with value k mod 128, then SCROLL_UP char 0x00 with vga_rdn toggling every 8 cycles -> cell i = (i+80) mod 128 for i<4720, row 59 all 0x00; vram_addrb=vga_addr whenever vga_rdn=0.
- cmd_valid held during a busy CLEAR_ALL with a different op -> second command ignored; exactly one done.
- RSTN low mid-SCROLL_UP -> immediate IDLE, cmd_ready=1, done=0; a new CLEAR_ALL then completes normally; without VRAM_CTRL_SCROLL_EN, SCROLL_UP produces done after one cycle with no writes.
